// File: rtl/div_8x4_seq_if.sv
// Handshake bundle for the 8x4 sequential divider: operand side (in_*)
// and result side (out_*), each with its own valid/ready pair.
`timescale 1ns/1ps
interface div_8x4_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Producer/consumer side.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_8x4_seq.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per cycle, valid/ready on both operand and result sides.
`timescale 1ns/1ps
module div_8x4_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input logic           clk,
  input logic           rst_n,
  div_8x4_seq_if.slave  bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;      // dividend, shifted out MSB first
  logic [VW-1:0] dvs_q, dvs_d;      // captured divisor
  logic [VW:0]   rem_q, rem_d;      // partial remainder, one guard bit
  logic [DW-1:0] quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   rem_shift;
  logic [VW:0]   dvs_ext;

  // Next-state: capture on accept, one restoring step per RUN cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;

    // The remainder is always < divisor, so dropping the top bit on shift is lossless.
    rem_shift = (rem_q << 1) | {{VW{1'b0}}, dvd_q[DW-1]};
    dvs_ext   = {1'b0, dvs_q};

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          dvd_d       = bus.dividend;
          dvs_d       = bus.divisor;
          rem_d       = '0;
          cnt_d       = CW'(DW - 1);
          out_valid_d = 1'b0;
          if (bus.divisor == '0) begin
            quot_d  = '1;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            quot_d  = '0;
            dbz_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        if (rem_shift >= dvs_ext) begin
          rem_d  = rem_shift - dvs_ext;
          quot_d = {quot_q[DW-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift;
          quot_d = {quot_q[DW-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        // Divide-by-zero arrives here with out_valid still low; raise it one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q[VW-1:0];
  assign bus.div_by_zero = dbz_q;

endmodule
